// File: rtl/lsu_mem_ctrl.sv
// Load/store memory sequencer: one outstanding data-memory access at a time, with byte-lane
// alignment, load extension, misalignment trap, flush and response timeout.
module lsu_mem_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_is_load_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  output logic [7:0]  mem_wmask_o,
  input  logic        mem_ready_i,
  input  logic        mem_rvalid_i,
  input  logic [63:0] mem_rdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        inst_is_load_o,
  output logic [63:0] load_data_o,
  output logic        misalign_o,
  output logic        err_o
);

  typedef enum logic [2:0] {IDLE, REQ, RESP, DONE, DRAIN} state_t;

  state_t           state;
  logic             is_load;
  logic [1:0]       size;
  logic [2:0]       offset;
  logic             is_unsigned;
  logic [CNT_W-1:0] cnt;

  logic             misaligned;
  logic [63:0]      wdata_rep;
  logic [63:0]      wdata_lane;
  logic [7:0]       mask_base;
  logic [7:0]       mask_lane;
  logic [63:0]      rlane;
  logic [63:0]      load_ext;
  logic [CNT_W-1:0] cnt_next;
  logic             timeout_hit;

  // Request decode happens in IDLE so the bus fields can be registered on the way into REQ.
  always_comb begin
    misaligned = 1'b0;
    wdata_rep  = req_wdata_i;
    mask_base  = 8'hFF;
    case (req_size_i)
      2'd0: begin
        wdata_rep = {8{req_wdata_i[7:0]}};
        mask_base = 8'h01;
      end
      2'd1: begin
        misaligned = req_addr_i[0];
        wdata_rep  = {4{req_wdata_i[15:0]}};
        mask_base  = 8'h03;
      end
      2'd2: begin
        misaligned = |req_addr_i[1:0];
        wdata_rep  = {2{req_wdata_i[31:0]}};
        mask_base  = 8'h0F;
      end
      default: misaligned = |req_addr_i[2:0];
    endcase
  end

  assign wdata_lane = wdata_rep << {req_addr_i[2:0], 3'b000};
  assign mask_lane  = mask_base << req_addr_i[2:0];

  assign rlane = mem_rdata_i >> {offset, 3'b000};

  always_comb begin
    load_ext = rlane;
    case (size)
      2'd0: load_ext = {{56{~is_unsigned & rlane[7]}}, rlane[7:0]};
      2'd1: load_ext = {{48{~is_unsigned & rlane[15]}}, rlane[15:0]};
      2'd2: load_ext = {{32{~is_unsigned & rlane[31]}}, rlane[31:0]};
      default: load_ext = rlane;
    endcase
  end

  assign cnt_next    = cnt + CNT_W'(1);
  assign timeout_hit = (cnt_next == CNT_W'(TIMEOUT));

  // Reset is folded in so the stall request is dropped the instant reset asserts.
  assign stall_o = rst & ((state == IDLE) ? (req_valid_i & ~flush_i)
                                          : (state == REQ || state == RESP || state == DRAIN));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      is_load        <= 1'b0;
      size           <= 2'd0;
      offset         <= 3'd0;
      is_unsigned    <= 1'b0;
      cnt            <= '0;
      mem_req_o      <= 1'b0;
      mem_we_o       <= 1'b0;
      mem_addr_o     <= 64'd0;
      mem_wdata_o    <= 64'd0;
      mem_wmask_o    <= 8'd0;
      done_o         <= 1'b0;
      inst_is_load_o <= 1'b0;
      load_data_o    <= 64'd0;
      misalign_o     <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      done_o         <= 1'b0;
      inst_is_load_o <= 1'b0;
      misalign_o     <= 1'b0;
      err_o          <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i && !flush_i) begin
            is_load     <= req_is_load_i;
            size        <= req_size_i;
            offset      <= req_addr_i[2:0];
            is_unsigned <= req_unsigned_i;
            if (misaligned) begin
              state          <= DONE;
              done_o         <= 1'b1;
              misalign_o     <= 1'b1;
              inst_is_load_o <= req_is_load_i;
            end else begin
              state       <= REQ;
              mem_req_o   <= 1'b1;
              mem_we_o    <= ~req_is_load_i;
              mem_addr_o  <= {req_addr_i[63:3], 3'b000};
              mem_wdata_o <= wdata_lane;
              mem_wmask_o <= mask_lane;
            end
          end
        end
        REQ: begin
          if (flush_i || mem_ready_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 64'd0;
            mem_wdata_o <= 64'd0;
            mem_wmask_o <= 8'd0;
            cnt         <= '0;
          end
          // An accepted load under flush still owes us a response, which must be swallowed.
          if (flush_i) begin
            state <= (mem_ready_i && is_load) ? DRAIN : IDLE;
          end else if (mem_ready_i) begin
            if (is_load) begin
              state <= RESP;
            end else begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end
        end
        RESP: begin
          if (flush_i) begin
            state <= (mem_rvalid_i || timeout_hit) ? IDLE : DRAIN;
            cnt   <= cnt_next;
          end else if (mem_rvalid_i) begin
            state          <= DONE;
            done_o         <= 1'b1;
            inst_is_load_o <= 1'b1;
            load_data_o    <= load_ext;
          end else if (timeout_hit) begin
            state          <= DONE;
            done_o         <= 1'b1;
            inst_is_load_o <= 1'b1;
            err_o          <= 1'b1;
          end else begin
            cnt <= cnt_next;
          end
        end
        DRAIN: begin
          if (mem_rvalid_i || timeout_hit) state <= IDLE;
          else cnt <= cnt_next;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed scenarios plus randomized accesses checked
// against a byte-level reference model of lane selection, extension and store formatting.
module tb_lsu_mem_ctrl;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_is_load_i, req_unsigned_i, flush_i;
  logic [63:0] req_addr_i, req_wdata_i;
  logic [1:0]  req_size_i;
  logic        mem_req_o, mem_we_o, mem_ready_i, mem_rvalid_i;
  logic [63:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [7:0]  mem_wmask_o;
  logic        stall_o, done_o, inst_is_load_o, misalign_o, err_o;
  logic [63:0] load_data_o;

  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_load_data = 64'd0;

  lsu_mem_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_is_load_i(req_is_load_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_ready_i(mem_ready_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .done_o(done_o), .inst_is_load_o(inst_is_load_o),
    .load_data_o(load_data_o), .misalign_o(misalign_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: gather the addressed bytes one at a time, then widen by the sign rule.
  function automatic logic [63:0] model_load(input logic [63:0] rd, input logic [63:0] addr,
                                             input logic [1:0] sz, input bit uns);
    int n;
    int off;
    logic [63:0] v;
    n   = 1 << sz;
    off = int'(addr[2:0]);
    v   = 64'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
    if (!uns && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_access(input string tag, input bit ld, input logic [63:0] addr,
                            input logic [1:0] sz, input logic [63:0] wd, input bit uns,
                            input int rdy_dly, input int rv_dly, input logic [63:0] rd);
    int n;
    int off;
    bit mis;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_mask;
    logic [63:0] exp_ld;
    n   = 1 << sz;
    off = int'(addr[2:0]);
    mis = (off % n) != 0;
    exp_wdata = 64'd0;
    exp_mask  = 8'd0;
    for (int j = 0; j < 8; j++) begin
      if (j >= off) exp_wdata[8*j +: 8] = wd[8*((j-off) % n) +: 8];
      exp_mask[j] = (j >= off) && (j < off + n);
    end

    next_cycle();
    req_valid_i = 1'b1; req_is_load_i = ld; req_addr_i = addr; req_size_i = sz;
    req_wdata_i = wd; req_unsigned_i = uns;
    @(negedge clk);
    check({tag, "/stall_c0"}, stall_o, 1'b1);
    check({tag, "/req_c0"}, mem_req_o, 1'b0);

    if (mis) begin
      next_cycle();
      @(negedge clk);
      check({tag, "/mis_done"}, done_o, 1'b1);
      check({tag, "/mis_flag"}, misalign_o, 1'b1);
      check({tag, "/mis_req"}, mem_req_o, 1'b0);
      check({tag, "/mis_err"}, err_o, 1'b0);
      check({tag, "/mis_isld"}, inst_is_load_o, ld);
      check({tag, "/mis_stall"}, stall_o, 1'b0);
    end else begin
      for (int k = 0; k <= rdy_dly; k++) begin
        next_cycle();
        mem_ready_i = (k == rdy_dly);
        @(negedge clk);
        check({tag, "/req"}, mem_req_o, 1'b1);
        check({tag, "/req_stall"}, stall_o, 1'b1);
        check({tag, "/req_done"}, done_o, 1'b0);
        if (k == 0) begin
          check({tag, "/addr"}, mem_addr_o, {addr[63:3], 3'b000});
          check({tag, "/we"}, mem_we_o, !ld);
          if (!ld) begin
            check({tag, "/wdata"}, mem_wdata_o, exp_wdata);
            check({tag, "/wmask"}, mem_wmask_o, exp_mask);
          end
        end
      end
      if (ld) begin
        for (int k = 0; k <= rv_dly; k++) begin
          next_cycle();
          mem_ready_i  = 1'b0;
          mem_rvalid_i = (k == rv_dly);
          mem_rdata_i  = (k == rv_dly) ? rd : {$urandom, $urandom};
          @(negedge clk);
          check({tag, "/resp_stall"}, stall_o, 1'b1);
          check({tag, "/resp_done"}, done_o, 1'b0);
          check({tag, "/resp_req"}, mem_req_o, 1'b0);
        end
        exp_ld = model_load(rd, addr, sz, uns);
        exp_load_data = exp_ld;
        next_cycle();
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        check({tag, "/ld_done"}, done_o, 1'b1);
        check({tag, "/ld_isld"}, inst_is_load_o, 1'b1);
        check({tag, "/ld_data"}, load_data_o, exp_ld);
        check({tag, "/ld_err"}, err_o, 1'b0);
        check({tag, "/ld_stall"}, stall_o, 1'b0);
      end else begin
        next_cycle();
        mem_ready_i = 1'b0;
        @(negedge clk);
        check({tag, "/st_done"}, done_o, 1'b1);
        check({tag, "/st_isld"}, inst_is_load_o, 1'b0);
        check({tag, "/st_mis"}, misalign_o, 1'b0);
        check({tag, "/st_stall"}, stall_o, 1'b0);
        check({tag, "/st_hold"}, load_data_o, exp_load_data);
      end
    end

    // The request is still presented during the completion cycle and must not restart.
    next_cycle();
    req_valid_i  = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = {$urandom, $urandom};
    @(negedge clk);
    check({tag, "/after_done"}, done_o, 1'b0);
    check({tag, "/after_req"}, mem_req_o, 1'b0);
    check({tag, "/after_stall"}, stall_o, 1'b0);
    next_cycle();
    mem_rvalid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req_valid_i = 1'b0; req_is_load_i = 1'b0; req_addr_i = 64'd0; req_wdata_i = 64'd0;
    req_size_i = 2'd0; req_unsigned_i = 1'b0; flush_i = 1'b0;
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset/req", mem_req_o, 1'b0);
    check("reset/stall", stall_o, 1'b0);
    check("reset/done", done_o, 1'b0);
    check("reset/load_data", load_data_o, 64'd0);
    check("reset/wmask", mem_wmask_o, 8'd0);
    rst = 1'b1;

    run_access("ld_double", 1'b1, 64'h80001000, 2'd3, 64'd0, 1'b0, 0, 0, 64'h1122334455667788);
    run_access("ld_sbyte", 1'b1, 64'h80001005, 2'd0, 64'd0, 1'b0, 0, 0, 64'h000080FF00000000);
    run_access("ld_ubyte", 1'b1, 64'h80001005, 2'd0, 64'd0, 1'b1, 1, 2, 64'h000080FF00000000);
    run_access("st_half", 1'b0, 64'h80001006, 2'd1, 64'h000000000000ABCD, 1'b0, 3, 0, 64'd0);
    run_access("ld_word_mis", 1'b1, 64'h80001002, 2'd2, 64'd0, 1'b0, 0, 0, 64'd0);

    // Flush while waiting for a response: the late response is swallowed.
    next_cycle();
    req_valid_i = 1'b1; req_is_load_i = 1'b1; req_addr_i = 64'h80001008; req_size_i = 2'd3;
    next_cycle();
    mem_ready_i = 1'b1;
    next_cycle();
    mem_ready_i = 1'b0; flush_i = 1'b1; req_valid_i = 1'b0;
    @(negedge clk);
    check("flush/resp_stall", stall_o, 1'b1);
    next_cycle();
    flush_i = 1'b0;
    @(negedge clk);
    check("flush/drain_stall", stall_o, 1'b1);
    check("flush/drain_done", done_o, 1'b0);
    next_cycle();
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'hDEADBEEFCAFEF00D;
    @(negedge clk);
    check("flush/drain_stall2", stall_o, 1'b1);
    next_cycle();
    mem_rvalid_i = 1'b0;
    @(negedge clk);
    check("flush/no_done", done_o, 1'b0);
    check("flush/idle_stall", stall_o, 1'b0);
    check("flush/data_kept", load_data_o, exp_load_data);
    run_access("after_flush", 1'b1, 64'h80001010, 2'd2, 64'd0, 1'b0, 0, 1, 64'h89ABCDEF_80000001);

    // No response at all: abort after TIMEOUT cycles in RESP.
    next_cycle();
    req_valid_i = 1'b1; req_is_load_i = 1'b1; req_addr_i = 64'h80001018; req_size_i = 2'd3;
    next_cycle();
    mem_ready_i = 1'b1;
    for (int k = 0; k < TIMEOUT; k++) begin
      next_cycle();
      mem_ready_i = 1'b0;
      @(negedge clk);
      check("tmo/wait_done", done_o, 1'b0);
      check("tmo/wait_stall", stall_o, 1'b1);
    end
    next_cycle();
    @(negedge clk);
    check("tmo/done", done_o, 1'b1);
    check("tmo/err", err_o, 1'b1);
    check("tmo/isld", inst_is_load_o, 1'b1);
    check("tmo/data_kept", load_data_o, exp_load_data);
    next_cycle();
    req_valid_i = 1'b0;
    @(negedge clk);
    check("tmo/err_pulse", err_o, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_access("rand", 1'($urandom_range(0, 1)), 64'h80002000 + 64'(8 * $urandom_range(0, 31))
                 + 64'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), {$urandom, $urandom},
                 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 2),
                 {$urandom, $urandom});
    end

    // Asynchronous reset in the middle of a bus request.
    next_cycle();
    req_valid_i = 1'b1; req_is_load_i = 1'b1; req_addr_i = 64'h80001020; req_size_i = 2'd3;
    next_cycle();
    @(negedge clk);
    check("rst/req_before", mem_req_o, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    exp_load_data = 64'd0;
    check("rst/req", mem_req_o, 1'b0);
    check("rst/stall", stall_o, 1'b0);
    check("rst/addr", mem_addr_o, 64'd0);
    check("rst/load_data", load_data_o, 64'd0);
    req_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'h0123456789ABCDEF;
    next_cycle();
    mem_rvalid_i = 1'b0;
    @(negedge clk);
    check("rst/late_resp_done", done_o, 1'b0);
    check("rst/late_resp_data", load_data_o, exp_load_data);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Sequences load/store requests from the execute stage onto a single-outstanding data-memory bus with a valid/ready request channel and a valid-only response channel.
- Produces the aligned, extended load value and the is-load flag that feed the MEM/WB pipeline register.
- Holds the front of the pipeline via stall_o while an access is in flight.
- Handles misalignment, flush and response timeout.

Parameters:
- TIMEOUT, 255, max cycles waited in RESP for mem_rvalid_i before aborting with err_o
- CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2^CNT_W

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid_i  in  1  execute stage presents a memory instruction; held stable while stall_o=1
- req_is_load_i  in  1  1=load, 0=store
- req_addr_i  in  64  byte address
- req_wdata_i  in  64  store data, right-aligned
- req_size_i  in  2  0=byte, 1=half, 2=word, 3=double
- req_unsigned_i  in  1  zero-extend load when 1
- flush_i  in  1  pipeline flush; abandons current access
- mem_req_o  out  1  bus request valid
- mem_we_o  out  1  bus write enable
- mem_addr_o  out  64  req_addr_i with bits [2:0] cleared
- mem_wdata_o  out  64  store data shifted to byte lane addr[2:0]
- mem_wmask_o  out  8  byte strobes
- mem_ready_i  in  1  bus accepts request this cycle
- mem_rvalid_i  in  1  read response valid
- mem_rdata_i  in  64  read response data
- stall_o  out  1  hold IF/ID/EX
- done_o  out  1  one-cycle pulse: access complete, results valid
- inst_is_load_o  out  1  completed access was a load (valid with done_o)
- load_data_o  out  64  extended load result (valid with done_o, held until next done_o)
- misalign_o  out  1  pulse with done_o when address not aligned to size
- err_o  out  1  pulse with done_o on response timeout

Behaviour:
- States: IDLE, REQ, RESP, DONE, DRAIN. Reset (rst=0, async) -> IDLE; all outputs 0, load_data_o=0, counter=0.
- IDLE: stall_o = req_valid_i & ~flush_i. On req_valid_i & ~flush_i:
  - misaligned (half: addr[0]!=0; word: addr[1:0]!=0; double: addr[2:0]!=0) -> DONE with misalign_o, no bus traffic;
  - otherwise latch request fields -> REQ.
- REQ: mem_req_o=1, fields from latched copy, stable until accepted. On mem_ready_i:
  - load -> RESP;
  - store -> DONE (stores complete on acceptance).
  - flush_i in REQ before acceptance -> IDLE, no done_o. flush_i in the accepting cycle with a load -> DRAIN; with a store -> IDLE (write is committed, no done_o).
- RESP: counter increments each cycle.
  - On mem_rvalid_i: extract the lane at byte offset addr[2:0] of the given size, sign/zero-extend per req_unsigned_i, register it into load_data_o -> DONE.
  - Counter reaching TIMEOUT without rvalid -> DONE with err_o=1, load_data_o unchanged.
  - flush_i -> DRAIN.
- DRAIN: stall_o=1. Discard the next mem_rvalid_i -> IDLE; timeout also -> IDLE. No done_o.
- DONE: exactly one cycle. done_o=1, stall_o=0, inst_is_load_o=latched is_load, misalign_o/err_o as set. The request still visible on req_valid_i this cycle is ignored -> IDLE.
- stall_o=1 in REQ, RESP, DRAIN.
- Store formatting:
  - mem_wdata_o = size-replicated req_wdata_i << (8*addr[2:0]);
  - mem_wmask_o = ((1<<(1<<size))-1) << addr[2:0];
  - mem_we_o=1 only for stores in REQ.
- Minimum load latency: request seen in IDLE cycle 0 -> mem_req_o cycle 1 -> rvalid cycle 2 -> done_o cycle 3. Minimum store: done_o cycle 2.
- mem_rvalid_i outside RESP/DRAIN is ignored. Reset mid-access returns to IDLE immediately; any later bus response is ignored.

Test Plan:
- Load double, addr 0x80001000, ready=1 at cycle 1, rvalid cycle 2 with rdata 0x1122334455667788 -> done_o cycle 3, load_data_o=0x1122334455667788, inst_is_load_o=1, stall_o high cycles 0-2.
- Signed byte load, addr 0x80001005, rdata 0x0000_80FF_0000_0000 -> lane byte 0x80, load_data_o=0xFFFFFFFFFFFFFF80; same with req_unsigned_i=1 -> 0x80.
- Store half, addr 0x80001006, wdata 0xABCD, ready delayed 3 cycles -> mem_req_o held 4 cycles with mem_addr_o=0x80001000, mem_wmask_o=0xC0, mem_wdata_o[63:48]=0xABCD, done_o one cycle after acceptance.
- Word load at addr 0x80001002 -> no mem_req_o, done_o+misalign_o pulse cycle 1.
- Load accepted, flush_i in RESP, rvalid 2 cycles later -> no done_o, response discarded, IDLE; next request proceeds normally.
- Load accepted, no rvalid, TIMEOUT=4 -> err_o+done_o after 4 RESP cycles; async rst asserted mid-REQ -> all outputs 0 immediately.
